// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: RV32I funct3 encodings and FSM states.
package load_store_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_load_extend.sv
// Load lane select plus sign/zero extension of a 32-bit read word.
module lsu_load_extend
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = rdata[{off, 3'b000} +: 8];
    h    = rdata[{off[1], 4'b0000} +: 16];
    data = '0;
    case (funct3)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LW:   data = rdata;
      F3_LBU:  data = {24'h0, b};
      F3_LHU:  data = {16'h0, h};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit with req/gnt/rvalid bus handshake.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  is_load_i,
  input  logic                  is_store_i,
  input  logic [2:0]            funct3_i,
  input  logic [AWIDTH-1:0]     addr_i,
  input  logic [DWIDTH-1:0]     store_data_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [AWIDTH-1:0]     mem_addr_o,
  output logic [DWIDTH/8-1:0]   mem_be_o,
  output logic [DWIDTH-1:0]     mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DWIDTH-1:0]     mem_rdata_i,
  output logic                  rsp_valid_o,
  output logic [DWIDTH-1:0]     rsp_data_o,
  output logic                  misalign_o
);

  lsu_state_e          state;
  logic [2:0]          f3_q;
  logic [1:0]          off_q;
  logic                ld_q;

  logic [1:0]          off;
  logic                st;
  logic                half;
  logic                word;
  logic                trap;
  logic [DWIDTH/8-1:0] be;
  logic [DWIDTH-1:0]   wdata;
  logic [DWIDTH-1:0]   ext_data;

  always_comb begin
    st   = is_store_i & ~is_load_i;
    half = is_load_i ? (funct3_i == F3_LH || funct3_i == F3_LHU)
                     : (funct3_i == F3_SH);
    word = is_load_i ? (funct3_i == F3_LW) : (funct3_i == F3_SW);
    off  = addr_i[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (is_load_i | is_store_i)
         & ((half & off[0]) | (word & (off != 2'b00)));
`else
    trap = 1'b0;
    if (half) off[0] = 1'b0;
    if (word) off = 2'b00;
`endif
    be    = '0;
    wdata = store_data_i;
    case (funct3_i)
      F3_SB: begin
        be    = 4'b0001 << off;
        wdata = {4{store_data_i[7:0]}};
      end
      F3_SH: begin
        be    = 4'b0011 << {off[1], 1'b0};
        wdata = {2{store_data_i[15:0]}};
      end
      F3_SW:   be = 4'hF;
      default: be = '0;
    endcase
    if (is_load_i) be = '1;
  end

  lsu_load_extend u_ext (
    .rdata  (mem_rdata_i),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      misalign_o  <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      ld_q        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (req_valid_i) begin
          req_ready_o <= 1'b0;
          f3_q        <= funct3_i;
          off_q       <= off;
          ld_q        <= is_load_i;
          mem_we_o    <= st;
          mem_addr_o  <= {addr_i[AWIDTH-1:2], 2'b00};
          mem_be_o    <= be;
          mem_wdata_o <= wdata;
          if (!(is_load_i | is_store_i) || trap) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= '0;
            misalign_o  <= trap;
          end else begin
            state     <= REQ;
            mem_req_o <= 1'b1;
          end
        end
        REQ: if (mem_gnt_i) begin
          mem_req_o <= 1'b0;
          if (ld_q) begin
            state <= WAIT;
          end else begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
            misalign_o  <= 1'b0;
          end
        end
        WAIT: if (mem_rvalid_i) begin
          state       <= RESP;
          rsp_valid_o <= 1'b1;
          rsp_data_o  <= ext_data;
          misalign_o  <= 1'b0;
        end
        RESP: begin
          state       <= IDLE;
          rsp_valid_o <= 1'b0;
          misalign_o  <= 1'b0;
          req_ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        is_load_i;
  logic        is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        misalign_o;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .is_load_i    (is_load_i),
    .is_store_i   (is_store_i),
    .funct3_i     (funct3_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .misalign_o   (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_data;
    int          gd;
    int          rd;
  } vec_t;

  vec_t vecs[13];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic idle_inputs();
    req_valid_i  = 1'b0;
    is_load_i    = 1'b0;
    is_store_i   = 1'b0;
    funct3_i     = 3'b000;
    addr_i       = 32'h0;
    store_data_i = 32'h0;
  endtask

  task automatic drive_req(input vec_t v);
    req_valid_i  = 1'b1;
    is_load_i    = v.ld;
    is_store_i   = v.st;
    funct3_i     = v.f3;
    addr_i       = v.addr;
    store_data_i = v.sdata;
  endtask

  // Full bus access with gd cycles of withheld gnt and rd idle cycles before rvalid.
  task automatic access(input vec_t v);
    logic we;
    we = v.st & ~v.ld;
    @(negedge clk);
    chk("ready_idle", {31'h0, req_ready_o}, 32'h1);
    drive_req(v);
    @(negedge clk);
    idle_inputs();
    for (int i = 0; i <= v.gd; i++) begin
      chk("mem_req", {31'h0, mem_req_o}, 32'h1);
      chk("mem_addr", mem_addr_o, v.exp_addr);
      chk("mem_we", {31'h0, mem_we_o}, {31'h0, we});
      chk("ready_busy", {31'h0, req_ready_o}, 32'h0);
      if (we) begin
        chk("mem_be", {28'h0, mem_be_o}, {28'h0, v.exp_be});
        chk("mem_wdata", mem_wdata_o, v.exp_wdata);
      end
      if (i == v.gd) mem_gnt_i = 1'b1;
      @(negedge clk);
      mem_gnt_i = 1'b0;
    end
    if (v.ld) begin
      for (int i = 0; i <= v.rd; i++) begin
        chk("no_early_rsp", {31'h0, rsp_valid_o}, 32'h0);
        chk("req_dropped", {31'h0, mem_req_o}, 32'h0);
        if (i == v.rd) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = v.rdata;
        end
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
      end
    end
    chk("rsp_valid", {31'h0, rsp_valid_o}, 32'h1);
    chk("misalign_clr", {31'h0, misalign_o}, 32'h0);
    if (v.ld) chk("rsp_data", rsp_data_o, v.exp_data);
    @(negedge clk);
    chk("rsp_pulse", {31'h0, rsp_valid_o}, 32'h0);
    chk("ready_back", {31'h0, req_ready_o}, 32'h1);
  endtask

  initial begin
    vec_t v;
    //          ld    st    f3      addr           sdata          rdata          exp_addr       be       wdata          data           gd rd
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         32'h0000_0100, 4'hF,    32'hDEAD_BEEF, 32'h0,         0, 0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF_1234, 32'h0000_0100, 4'h0,    32'h0,         32'hFFFF_FF80, 0, 0};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,         32'h80FF_1234, 32'h0000_0100, 4'h0,    32'h0,         32'h0000_0080, 0, 0};
    vecs[3]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h0,         32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 32'h0,         1, 0};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,         32'hABCD_0000, 32'h0000_0100, 4'h0,    32'h0,         32'h0000_ABCD, 0, 1};
    vecs[5]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0100, 32'h0,         32'h1234_8001, 32'h0000_0100, 4'h0,    32'h0,         32'hFFFF_8001, 0, 0};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h1234_565A, 32'h0,         32'h0000_0200, 4'b0010, 32'h5A5A_5A5A, 32'h0,         0, 0};
    vecs[7]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, 32'h0000_0300, 4'h0,    32'h0,         32'hCAFE_F00D, 3, 2};
    vecs[8]  = '{1'b1, 1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'hFFFF_FFFF, 32'h0000_0010, 4'h0,    32'h0,         32'h0,         0, 0};
    vecs[9]  = '{1'b0, 1'b1, 3'b011, 32'h0000_0014, 32'h1111_2222, 32'h0,         32'h0000_0014, 4'h0,    32'h1111_2222, 32'h0,         0, 0};
    vecs[10] = '{1'b1, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0,         32'h7F00_0000, 32'hFFFF_FFFC, 4'h0,    32'h0,         32'h0000_007F, 0, 0};
    vecs[11] = '{1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0,         32'h0000_FFFF, 32'h0000_0000, 4'h0,    32'h0,         32'h0000_FFFF, 2, 0};
    vecs[12] = '{1'b1, 1'b1, 3'b010, 32'h0000_0040, 32'h9999_9999, 32'h55AA_55AA, 32'h0000_0040, 4'h0,    32'h0,         32'h55AA_55AA, 0, 0};

    idle_inputs();
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    reset        = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready_o}, 32'h1);
    chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("rst_rsp_data", rsp_data_o, 32'h0);
    chk("rst_misalign", {31'h0, misalign_o}, 32'h0);
    chk("rst_be", {28'h0, mem_be_o}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) access(vecs[i]);

    // Request with neither load nor store: direct response with zero data.
    @(negedge clk);
    req_valid_i = 1'b1;
    funct3_i    = 3'b010;
    addr_i      = 32'h0000_0500;
    @(negedge clk);
    idle_inputs();
    chk("nop_rsp", {31'h0, rsp_valid_o}, 32'h1);
    chk("nop_data", rsp_data_o, 32'h0);
    chk("nop_no_bus", {31'h0, mem_req_o}, 32'h0);
    @(negedge clk);
    chk("nop_pulse", {31'h0, rsp_valid_o}, 32'h0);
    chk("nop_ready", {31'h0, req_ready_o}, 32'h1);

    // Reset while REQ: mem_req_o drops immediately.
    v = vecs[1];
    @(negedge clk);
    drive_req(v);
    @(negedge clk);
    idle_inputs();
    chk("req_before_rst", {31'h0, mem_req_o}, 32'h1);
    reset = 1'b1;
    #1;
    chk("req_async_drop", {31'h0, mem_req_o}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Load to fill rsp_data, then reset in WAIT with late rvalid.
    access(vecs[7]);
    @(negedge clk);
    drive_req(vecs[1]);
    @(negedge clk);
    idle_inputs();
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    reset = 1'b1;
    #1;
    chk("wait_rst_data", rsp_data_o, 32'h0);
    chk("wait_rst_ready", {31'h0, req_ready_o}, 32'h1);
    @(negedge clk);
    reset        = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h80FF_1234;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_rst_no_rsp", {31'h0, rsp_valid_o}, 32'h0);
      chk("wait_rst_no_req", {31'h0, mem_req_o}, 32'h0);
      @(negedge clk);
    end
    chk("wait_rst_idle", {31'h0, req_ready_o}, 32'h1);
    chk("wait_rst_data2", rsp_data_o, 32'h0);

`ifdef LSU_MISALIGN_TRAP_EN
    v = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 0, 0};
    access(vecs[7]);
    @(negedge clk);
    drive_req(v);
    @(negedge clk);
    idle_inputs();
    chk("trap_rsp", {31'h0, rsp_valid_o}, 32'h1);
    chk("trap_misalign", {31'h0, misalign_o}, 32'h1);
    chk("trap_data", rsp_data_o, 32'h0);
    chk("trap_no_bus", {31'h0, mem_req_o}, 32'h0);
    @(negedge clk);
    chk("trap_pulse", {31'h0, rsp_valid_o}, 32'h0);
    chk("trap_mis_clr", {31'h0, misalign_o}, 32'h0);
`else
    v = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1122_3344, 32'h0000_0100, 4'h0, 32'h0, 32'h1122_3344, 0, 0};
    access(v);
    v = '{1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'h0, 32'h8765_0000, 32'h0000_0100, 4'h0, 32'h0, 32'hFFFF_8765, 0, 0};
    access(v);
    v = '{1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0000_BEEF, 32'h0, 32'h0000_0100, 4'b0011, 32'hBEEF_BEEF, 32'h0, 0, 0};
    access(v);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
